// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx: SD card CMD-line frame transmitter.
// Builds the 48-bit command frame and shifts it out MSB-first, one bit per clock,
// then enforces an NCC-cycle idle gap before the next frame.
// Optional feature: define SD_CMD_TX_CRC7_EN to build the internal CRC7 generator;
// otherwise bits 7:1 of the frame come from crcin latched at start.
module sd_cmd_tx #(
    parameter int NCC = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmdidx,
    input  logic [31:0] arg,
    input  logic [6:0]  crcin,
    output logic        cmdout,
    output logic        cmdtsen,
    output logic        tcvcptdone,
    output logic        busy
);

    localparam int GW = (NCC > 1) ? $clog2(NCC) : 1;

    typedef enum logic [1:0] {IDLE, SEND, DONE, GAP} state_t;

    state_t        state_reg, state_next;
    logic [46:0]   shift_reg, shift_next;     // frame bits not yet on the line
    logic [5:0]    bit_cnt_reg, bit_cnt_next; // index of the bit currently driven
    logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
    logic          cmdout_reg, cmdout_next;
    logic          cmdtsen_reg, cmdtsen_next;
    logic          done_reg, done_next;
    logic          busy_reg, busy_next;

    logic [6:0]    crc7;
    logic [47:0]   frame;
    logic          gap_last;
    logic          ready;
    logic          accept;

`ifdef SD_CMD_TX_CRC7_EN
    // CRC7 (x^7+x^3+1, init 0) over start, transmission bit, index and argument,
    // unrolled as a 40-stage combinational chain evaluated at start.
    logic [39:0] crc_data;
    logic [6:0]  crc_chain [0:40];
    logic        crcin_unused;

    assign crc_data     = {2'b01, cmdidx, arg};
    assign crc_chain[0] = 7'd0;
    assign crcin_unused = ^crcin;

    generate
        for (genvar gi = 0; gi < 40; gi++) begin : g_crc
            logic fb;
            assign fb = crc_data[39-gi] ^ crc_chain[gi][6];
            assign crc_chain[gi+1] = {crc_chain[gi][5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
    endgenerate

    assign crc7 = crc_chain[40];
`else
    assign crc7 = crcin;
`endif

    assign frame    = {2'b01, cmdidx, arg, crc7, 1'b1};
    assign gap_last = (state_reg == GAP) && (gap_cnt_reg == GW'(NCC - 1));

    // The last gap cycle (or DONE when there is no gap) counts as free, so a
    // start held high is taken exactly NCC clocks after DONE: frames every 49+NCC.
    assign ready  = (state_reg == IDLE) || gap_last ||
                    ((state_reg == DONE) && (NCC == 0));
    assign accept = start && ready;

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        cmdout_next  = 1'b1;
        cmdtsen_next = 1'b0;
        done_next    = 1'b0;
        busy_next    = 1'b0;

        case (state_reg)
            IDLE: begin
            end
            SEND: begin
                cmdtsen_next = 1'b1;
                busy_next    = 1'b1;
                if (bit_cnt_reg == 6'd0) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    cmdout_next  = shift_reg[46];
                    shift_next   = {shift_reg[45:0], 1'b1};
                    bit_cnt_next = bit_cnt_reg - 6'd1;
                end
            end
            DONE: begin
                if (NCC == 0) begin
                    state_next = IDLE;
                end else begin
                    state_next   = GAP;
                    busy_next    = 1'b1;
                    gap_cnt_next = '0;
                end
            end
            GAP: begin
                if (gap_last) begin
                    state_next = IDLE;
                end else begin
                    busy_next    = 1'b1;
                    gap_cnt_next = gap_cnt_reg + GW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (accept) begin
            state_next   = SEND;
            shift_next   = frame[46:0];
            bit_cnt_next = 6'd47;
            gap_cnt_next = '0;
            cmdout_next  = frame[47];
            cmdtsen_next = 1'b1;
            busy_next    = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            cmdout_reg  <= 1'b1;
            cmdtsen_reg <= 1'b0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            cmdout_reg  <= cmdout_next;
            cmdtsen_reg <= cmdtsen_next;
            done_reg    <= done_next;
            busy_reg    <= busy_next;
        end
    end

    assign cmdout     = cmdout_reg;
    assign cmdtsen    = cmdtsen_reg;
    assign tcvcptdone = done_reg;
    assign busy       = busy_reg;

endmodule
